cim_wr_arbiter: RTL and testbench
=================================

// Module: cim_wr_arbiter
// PURPOSE
// - Shares one CIM crossbar write port between NUM_REQ input-buffer controllers.
// - Uses round-robin arbitration. A grant is held for one whole burst of BURST_LEN writes.
// - After a completed burst, issues a compute start to the CIM tile.
// - Sits between the per-layer input controllers and a single CIM tile's write/start interface.
// PARAMETERS
// - NUM_REQ    4    number of requesters (>=2)
// - DATA_W     8    width of a data word
// - XBAR_SIZE  256  crossbar rows; the address width is AW = $clog2(XBAR_SIZE)+1
// - BURST_LEN  256  writes per grant (1..XBAR_SIZE)
// PORTS
// - clk           in   1               clock
// - rst           in   1               synchronous reset, active-high
// - i_req         in   NUM_REQ         request per requester; must be held until granted
// - i_we          in   NUM_REQ         write strobe per requester
// - i_addr        in   NUM_REQ x AW    row address per requester
// - i_data        in   NUM_REQ x DATA_W  data per requester
// - o_gnt         out  NUM_REQ         one-hot grant
// - o_owner       out  $clog2(NUM_REQ)  index of the current or last grantee
// - i_cim_busy    in   1               CIM tile is computing
// - o_cim_we      out  1               write enable to CIM
// - o_cim_addr    out  AW              write address to CIM
// - o_cim_data    out  DATA_W          write data to CIM
// - o_cim_start   out  1               compute request; held until i_cim_busy is seen high
// - o_busy        out  1               high in every state except IDLE
// BEHAVIOUR
// - States: IDLE, BURST, START.
// - Reset: state=IDLE, rr_ptr=0, count=0, o_owner=0. All other outputs are 0 in the cycle after rst is sampled high, including mid-burst.
// - IDLE:
//   - If |i_req and !i_cim_busy: winner = first set i_req at index >= rr_ptr, wrapping modulo NUM_REQ.
//   - Register o_gnt[winner] and o_owner=winner, clear count, go to BURST. o_gnt is valid 1 cycle after i_req.
//   - If i_cim_busy is high, no grant is given and state stays IDLE.
// - BURST datapath:
//   - o_cim_we = i_we[owner].
//   - o_cim_addr/o_cim_data = i_addr/i_data[owner], combinational with zero latency.
//   - The addr/data outputs are 0 when o_cim_we=0.
//   - i_we from non-owners is ignored.
// - BURST counting:
//   - count increments on each cycle with i_we[owner]=1.
//   - The write with count==BURST_LEN-1 is the last write. On that cycle: next state START, o_gnt cleared.
// - BURST abort:
//   - If i_req[owner] falls before the last write, the burst aborts.
//   - On abort: o_cim_we is forced to 0 that cycle, state goes to IDLE, no start is issued, rr_ptr=owner+1.
// - START:
//   - o_cim_start=1 and o_cim_we=0.
//   - When i_cim_busy=1 is sampled: deassert start, rr_ptr=(owner+1)%NUM_REQ, go to IDLE.
//   - New grants are therefore only possible after the CIM has accepted the start.
// - Fairness: the requester just served has the lowest priority in the next arbitration.
// - Simultaneous events:
//   - If the last write coincides with i_req[owner] falling, the write completes the burst and START follows.
//   - A requester may re-assert i_req in the same cycle its burst ends. It is served only after the other pending requesters.
// - count width is $clog2(BURST_LEN+1). count never wraps; it is cleared on every grant.
// CONFIGURATION
// - ARB_STATS_EN defined:
//   - Adds output o_done_cnt, NUM_REQ x 16.
//   - Each entry is a per-requester saturating count of completed bursts (START reached).
//   - The counters hold at 16'hFFFF, do not count aborts, and are cleared by rst.
// - ARB_STATS_EN undefined:
//   - The port and counters do not exist.
//   - All other behaviour is identical.
// TESTING
// - Single request: i_req=4'b0001, i_we high for 256 cycles ->
//   - o_gnt=0001 one cycle later; 256 writes pass through with matching addr/data.
//   - Then o_cim_start=1 until i_cim_busy=1; then IDLE.
// - Contention: i_req=4'b1111 held -> grant order 0,1,2,3,0. Each grant covers exactly 256 writes and ends with one start handshake.
// - Busy gating: i_cim_busy=1 in IDLE with i_req=0010 -> no grant. Drop busy -> o_gnt=0010 the next cycle.
// - Abort: requester 2 drops i_req after 100 writes ->
//   - o_cim_we=0 that cycle and no o_cim_start.
//   - With i_req=1111, the next grant goes to requester 3.
// - Isolation and reset:
//   - Non-owner i_we=1 with different data -> o_cim_data always equals the owner's data.
//   - rst asserted mid-burst -> all outputs 0 next cycle; a subsequent request is granted from rr_ptr=0.
// - ARB_STATS_EN: 3 completed bursts by requester 1 plus 1 abort -> o_done_cnt[1]=3. Preloaded 16'hFFFF plus one more burst -> stays 16'hFFFF.

Source files
------------

// File: rtl/cim_wr_arbiter.sv
// cim_wr_arbiter: round-robin owner of one CIM crossbar write port.
// A grant lasts one BURST_LEN-write burst; a completed burst is
// followed by a compute-start handshake with the CIM tile.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_req/i_we        per-requester request and write strobe
//   i_addr/i_data     per-requester row address and data word
//   o_gnt/o_owner     one-hot grant, index of current/last grantee
//   i_cim_busy        CIM tile is computing (also start acknowledge)
//   o_cim_we/addr/data  write port towards the CIM tile
//   o_cim_start       compute request, held until i_cim_busy
//   o_busy            arbiter is not idle
//   o_done_cnt        per-requester completed-burst counters,
//                     present only when ARB_STATS_EN is defined
module cim_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int XBAR_SIZE = 256,
    parameter int BURST_LEN = 256,
    localparam int AW = $clog2(XBAR_SIZE) + 1,
    localparam int OW = $clog2(NUM_REQ),
    localparam int CW = $clog2(BURST_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0]             i_we,
    input  logic [NUM_REQ-1:0][AW-1:0]     i_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] i_data,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [OW-1:0]                  o_owner,
    input  logic                           i_cim_busy,
    output logic                           o_cim_we,
    output logic [AW-1:0]                  o_cim_addr,
    output logic [DATA_W-1:0]              o_cim_data,
    output logic                           o_cim_start,
    output logic                           o_busy
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]       o_done_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_START
    } state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        rr_q, rr_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;

    logic [OW-1:0]        win;
    logic                 found;
    logic [OW-1:0]        owner_nxt;
    logic                 own_we;
    logic                 own_req;
    logic                 last_wr;
    logic                 cim_we;

    // Index (base + off) modulo NUM_REQ, off in [0, NUM_REQ).
    function automatic logic [OW-1:0] rot_idx(
        input logic [OW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return OW'(s);
    endfunction

    // First requester at or after rr_q, wrapping.
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i_req[rot_idx(rr_q, i)]) begin
                found = 1'b1;
                win   = rot_idx(rr_q, i);
            end
        end
    end

    assign owner_nxt = rot_idx(owner_q, 1);
    assign own_we    = i_we[owner_q];
    assign own_req   = i_req[owner_q];
    assign last_wr   = own_we && (cnt_q == CW'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        cim_we      = 1'b0;
        o_cim_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((|i_req) && !i_cim_busy) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    cnt_d      = '0;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                // The final write survives a same-cycle request drop.
                cim_we = own_we && (own_req || last_wr);
                if (last_wr) begin
                    cnt_d   = cnt_q + CW'(1);
                    gnt_d   = '0;
                    state_d = S_START;
                end else if (!own_req) begin
                    gnt_d   = '0;
                    rr_d    = owner_nxt;
                    state_d = S_IDLE;
                end else if (own_we) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_START: begin
                o_cim_start = 1'b1;
                if (i_cim_busy) begin
                    rr_d    = owner_nxt;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_gnt      = gnt_q;
    assign o_owner    = owner_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_cim_we   = cim_we;
    assign o_cim_addr = cim_we ? i_addr[owner_q] : '0;
    assign o_cim_data = cim_we ? i_data[owner_q] : '0;

`ifdef ARB_STATS_EN
    logic                      done_inc;
    logic [NUM_REQ-1:0][15:0]  done_q;

    assign done_inc = (state_q == S_BURST) && last_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
        end else if (done_inc && (done_q[owner_q] != 16'hFFFF)) begin
            done_q[owner_q] <= done_q[owner_q] + 16'd1;
        end
    end

    assign o_done_cnt = done_q;
`endif

endmodule

// File: tb/tb_cim_wr_arbiter.sv
// tb_cim_wr_arbiter: directed and random stimulus for cim_wr_arbiter
// against a transaction-level reference of the arbitration rules.
module tb_cim_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 9;
    localparam int BL = 256;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           i_req = '0;
    logic [N-1:0]           i_we = '0;
    logic [N-1:0][AW-1:0]   i_addr = '0;
    logic [N-1:0][DW-1:0]   i_data = '0;
    logic [N-1:0]           o_gnt;
    logic [1:0]             o_owner;
    logic                   i_cim_busy = 1'b0;
    logic                   o_cim_we;
    logic [AW-1:0]          o_cim_addr;
    logic [DW-1:0]          o_cim_data;
    logic                   o_cim_start;
    logic                   o_busy;
`ifdef ARB_STATS_EN
    logic [N-1:0][15:0]     o_done_cnt;
`endif

    cim_wr_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .XBAR_SIZE(256),
        .BURST_LEN(BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_gnt      (o_gnt),
        .o_owner    (o_owner),
        .i_cim_busy (i_cim_busy),
        .o_cim_we   (o_cim_we),
        .o_cim_addr (o_cim_addr),
        .o_cim_data (o_cim_data),
        .o_cim_start(o_cim_start),
        .o_busy     (o_busy)
`ifdef ARB_STATS_EN
        ,
        .o_done_cnt (o_done_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: who holds the port, whether a start is pending,
    // writes done in the current burst, next-priority requester.
    int holder  = -1;
    bit waiting = 1'b0;
    int written = 0;
    int m_ptr   = 0;
    int m_owner = 0;
    int done [N];
    bit busy_base = 1'b0;

    // Observations of the DUT, judged at scenario level.
    int writes = 0;
    int hs     = 0;
    int glog[$];
    logic [N-1:0] prev_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_rand();
        for (int r = 0; r < N; r++) begin
            i_addr[r] = AW'($urandom);
            i_data[r] = DW'($urandom);
            i_we[r]   = ($urandom_range(0, 7) != 0);
        end
        if (waiting) i_cim_busy = ($urandom_range(0, 2) == 0);
        else if (holder >= 0) i_cim_busy = ($urandom_range(0, 1) == 0);
        else i_cim_busy = busy_base;
    endtask

    task automatic cycle();
        logic [N-1:0]  eg;
        logic          ew;
        logic          lastw;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        eg = '0;
        ew = 1'b0;
        lastw = 1'b0;
        ea = '0;
        ed = '0;
        if (holder >= 0) begin
            eg[holder] = 1'b1;
            lastw = i_we[holder] && (written == BL - 1);
            ew = i_we[holder] && (i_req[holder] || lastw);
            if (ew) begin
                ea = i_addr[holder];
                ed = i_data[holder];
            end
        end
        if (!rst) begin
            chk("gnt", 32'(o_gnt), 32'(eg));
            chk("owner", 32'(o_owner), m_owner);
            chk("cim_we", 32'(o_cim_we), 32'(ew));
            chk("cim_addr", 32'(o_cim_addr), 32'(ea));
            chk("cim_data", 32'(o_cim_data), 32'(ed));
            chk("start", 32'(o_cim_start), 32'(waiting));
            chk("busy", 32'(o_busy), 32'(holder >= 0 || waiting));
`ifdef ARB_STATS_EN
            for (int r = 0; r < N; r++)
                chk("done_cnt", 32'(o_done_cnt[r]), done[r]);
`endif
            if (o_gnt != '0 && prev_gnt == '0) glog.push_back(int'(o_owner));
            prev_gnt = o_gnt;
            if (o_cim_we) writes++;
            if (o_cim_start && i_cim_busy) hs++;
        end
        if (rst) begin
            holder = -1;
            waiting = 1'b0;
            written = 0;
            m_ptr = 0;
            m_owner = 0;
            for (int r = 0; r < N; r++) done[r] = 0;
        end else if (waiting) begin
            if (i_cim_busy) begin
                waiting = 1'b0;
                m_ptr = (m_owner + 1) % N;
            end
        end else if (holder >= 0) begin
            if (lastw) begin
                waiting = 1'b1;
                holder = -1;
                written++;
                if (done[m_owner] < 65535) done[m_owner]++;
            end else if (!i_req[holder]) begin
                holder = -1;
                m_ptr = (m_owner + 1) % N;
            end else if (i_we[holder]) begin
                written++;
            end
        end else if (i_req != '0 && !i_cim_busy) begin
            holder = pick(i_req, m_ptr);
            m_owner = holder;
            written = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'(o_gnt), 0);
        chk({tag, "_owner"}, 32'(o_owner), 0);
        chk({tag, "_we"}, 32'(o_cim_we), 0);
        chk({tag, "_addr"}, 32'(o_cim_addr), 0);
        chk({tag, "_data"}, 32'(o_cim_data), 0);
        chk({tag, "_start"}, 32'(o_cim_start), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
`ifdef ARB_STATS_EN
        for (int r = 0; r < N; r++)
            chk({tag, "_done"}, 32'(o_done_cnt[r]), 0);
`endif
    endtask

    task automatic clr_obs();
        writes = 0;
        hs = 0;
        glog.delete();
        prev_gnt = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = '0;
        busy_base = 1'b0;
        drive_rand();
        cycle();
        rst = 1'b0;
        i_cim_busy = 1'b0;
        check_zero("rst");
        clr_obs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        do_reset();

        // Single requester: full burst then start handshake.
        i_req = 4'b0001;
        drive_rand();
        cycle();
        chk("B_gnt", 32'(o_gnt), 32'h1);
        for (int k = 0; k < 2000 && hs < 1; k++) begin
            if (waiting) i_req = '0;
            drive_rand();
            cycle();
        end
        chk("B_hs", hs, 1);
        chk("B_writes", writes, BL);
        chk("B_ngnt", glog.size(), 1);
        drive_rand();
        cycle();
        chk("B_idle", 32'(o_busy), 0);

        // Contention: all four requesting.
        do_reset();
        i_req = 4'b1111;
        for (int k = 0; k < 4000 && hs < 5; k++) begin
            drive_rand();
            cycle();
        end
        chk("C_hs", hs, 5);
        chk("C_writes", writes, 5 * BL);
        chk("C_ngnt", glog.size(), 5);
        for (int k = 0; k < glog.size() && k < 5; k++)
            chk("C_order", glog[k], k % N);

        // Busy gating in IDLE.
        do_reset();
        busy_base = 1'b1;
        i_req = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            drive_rand();
            cycle();
            chk("D_hold", 32'(o_gnt), 0);
        end
        busy_base = 1'b0;
        drive_rand();
        cycle();
        chk("D_gnt", 32'(o_gnt), 32'h2);

        // Abort of requester 2 after 100 writes.
        do_reset();
        i_req = 4'b0100;
        drive_rand();
        cycle();
        for (int k = 0; k < 1000 && written < 100; k++) begin
            drive_rand();
            cycle();
        end
        chk("E_w100", writes, 100);
        i_req = 4'b1011;
        drive_rand();
        i_we = '1;
        i_cim_busy = 1'b0;
        cycle();
        chk("E_nowr", writes, 100);
        i_req = 4'b1111;
        drive_rand();
        cycle();
        chk("E_owner", 32'(o_owner), 3);
        chk("E_gnt", 32'(o_gnt), 32'h8);
        chk("E_nohs", hs, 0);

        // Isolation with random non-owner traffic, then reset mid-burst.
        for (int k = 0; k < 50; k++) begin
            drive_rand();
            cycle();
        end
        chk("F_mid", 32'(o_busy), 1);
        rst = 1'b1;
        i_we = '1;
        cycle();
        rst = 1'b0;
        check_zero("F_rst");
        drive_rand();
        cycle();
        chk("F_owner", 32'(o_owner), 0);
        chk("F_gnt", 32'(o_gnt), 32'h1);

`ifdef ARB_STATS_EN
        // Three completed bursts and one abort by requester 1.
        do_reset();
        i_req = 4'b0010;
        for (int k = 0; k < 3000 && hs < 3; k++) begin
            drive_rand();
            cycle();
        end
        chk("G_hs", hs, 3);
        for (int k = 0; k < 500 && !(holder == 1 && written >= 50); k++) begin
            drive_rand();
            cycle();
        end
        i_req = '0;
        drive_rand();
        cycle();
        chk("G_done1", 32'(o_done_cnt[1]), 3);
        chk("G_done0", 32'(o_done_cnt[0]), 0);
`endif

        // Random request patterns.
        do_reset();
        i_req = 4'($urandom);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) i_req = 4'($urandom);
            drive_rand();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
